// File: rtl/vote_pkg.sv
// Shared types and constants for the vote booth arbiter: session states,
// vote encoding and the one-hot validity check.
package vote_pkg;

  localparam int VOTE_W = 4;
  localparam int CNT_W  = 5;

  // Bit positions inside a 4-bit vote {opt1, opt2, opt3, abstain}
  localparam int OPT1 = 3;
  localparam int OPT2 = 2;
  localparam int OPT3 = 1;
  localparam int ABS  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OPEN   = 2'b01,
    CLOSED = 2'b10
  } session_e;

  function automatic logic is_one_hot(input logic [VOTE_W-1:0] v);
    logic [2:0] ones;
    ones = 3'(v[OPT1]) + 3'(v[OPT2]) + 3'(v[OPT3]) + 3'(v[ABS]);
    return ones == 3'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first available requester at or after the
// pointer; the pointer moves to grant+1 whenever a grant is consumed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o,
  output logic         grant_valid_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx, gidx;
  logic [N-1:0]     avail;
  logic             found;

  // Masked booths already have a response in flight this cycle
  assign avail = req_i & ~mask_i;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % N);
      if (!found && avail[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  assign grant_valid_o = found;
  assign grant_o       = found ? ({{(N-1){1'b0}}, 1'b1} << gidx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (gidx == PTR_W'(N-1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vote_booth_arbiter.sv
// Election session controller: sequences IDLE/OPEN/CLOSED, arbitrates booth
// requests round-robin and forwards one validated vote per cycle to the tally.
module vote_booth_arbiter
  import vote_pkg::*;
#(
  parameter int NUM_BOOTHS = 4,
  parameter int CNT_W      = vote_pkg::CNT_W,
  parameter int MAX_VOTES  = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         open_i,
  input  logic                         close_i,
  input  logic [NUM_BOOTHS-1:0]        booth_req,
  input  logic [VOTE_W*NUM_BOOTHS-1:0] booth_vote,
  output logic [NUM_BOOTHS-1:0]        booth_ack,
  output logic [NUM_BOOTHS-1:0]        booth_nack,
  output logic [VOTE_W-1:0]            tally_vote,
  output logic                         tally_en,
  output logic                         tally_clr,
  output logic [1:0]                   session_state,
  output logic [CNT_W-1:0]             total_votes,
  output logic                         session_done
);

  session_e                state_q, state_d;
  logic [NUM_BOOTHS-1:0]   ack_q, ack_d;
  logic [NUM_BOOTHS-1:0]   nack_q, nack_d;
  logic [VOTE_W-1:0]       tvote_q, tvote_d;
  logic                    ten_q, ten_d;
  logic                    clr_q, clr_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        total_q, total_d;

  logic [NUM_BOOTHS-1:0]   grant;
  logic                    grant_valid;
  logic [VOTE_W-1:0]       sel_vote;

  rr_arbiter #(.N(NUM_BOOTHS)) u_arb (
    .clk           (clk),
    .reset         (reset),
    .req_i         (booth_req),
    .mask_i        (ack_q | nack_q),
    .advance_i     (grant_valid),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    sel_vote = '0;
    for (int b = 0; b < NUM_BOOTHS; b++) begin
      if (grant[b]) sel_vote |= booth_vote[VOTE_W*b +: VOTE_W];
    end
  end

  // Vote decision uses the pre-edge state; session transitions follow it
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    ack_d   = '0;
    nack_d  = '0;
    tvote_d = '0;
    ten_d   = 1'b0;
    clr_d   = 1'b0;

    if (grant_valid) begin
      if (state_q == OPEN && is_one_hot(sel_vote)) begin
        ack_d   = grant;
        tvote_d = sel_vote;
        ten_d   = 1'b1;
        total_d = total_q + 1'b1;
      end else begin
        nack_d = grant;
      end
    end

    unique case (state_q)
      IDLE, CLOSED: begin
        if (open_i) begin
          state_d = OPEN;
          clr_d   = 1'b1;
          total_d = '0;
        end
      end
      OPEN: begin
        if (close_i || (ten_d && total_d == CNT_W'(MAX_VOTES))) state_d = CLOSED;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == CLOSED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      total_q <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      tvote_q <= '0;
      ten_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      tvote_q <= tvote_d;
      ten_q   <= ten_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign booth_ack     = ack_q;
  assign booth_nack    = nack_q;
  assign tally_vote    = tvote_q;
  assign tally_en      = ten_q;
  assign tally_clr     = clr_q;
  assign session_state = state_q;
  assign total_votes   = total_q;
  assign session_done  = done_q;

endmodule

// File: tb/tb_vote_booth_arbiter.sv
// Scoreboard bench for vote_booth_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops and compares every DUT response.
module tb_vote_booth_arbiter;

  localparam int NB = 4;
  localparam int CW = 5;
  localparam int MV = 7;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_OPEN   = 2'b01;
  localparam logic [1:0] ST_CLOSED = 2'b10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            open_i = 1'b0;
  logic            close_i = 1'b0;
  logic [NB-1:0]   booth_req = '0;
  logic [4*NB-1:0] booth_vote = '0;
  logic [NB-1:0]   booth_ack, booth_nack;
  logic [3:0]      tally_vote;
  logic            tally_en, tally_clr;
  logic [1:0]      session_state;
  logic [CW-1:0]   total_votes;
  logic            session_done;

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] nack;
    logic [3:0] tv;
    logic       en;
    logic       clr;
    logic [1:0] st;
    logic [4:0] tot;
    logic       done;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    passes = 0;

  vote_booth_arbiter #(.NUM_BOOTHS(NB), .CNT_W(CW), .MAX_VOTES(MV)) dut (
    .clk           (clk),
    .reset         (reset),
    .open_i        (open_i),
    .close_i       (close_i),
    .booth_req     (booth_req),
    .booth_vote    (booth_vote),
    .booth_ack     (booth_ack),
    .booth_nack    (booth_nack),
    .tally_vote    (tally_vote),
    .tally_en      (tally_en),
    .tally_clr     (tally_clr),
    .session_state (session_state),
    .total_votes   (total_votes),
    .session_done  (session_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    resp_t a, e;
    if (!reset && (|booth_ack || |booth_nack || tally_clr || tally_en)) begin
      a = {booth_ack, booth_nack, tally_vote, tally_en, tally_clr,
           session_state, total_votes, session_done};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_resp got ack=%b nack=%b tv=%b en=%b clr=%b required no response",
                 booth_ack, booth_nack, tally_vote, tally_en, tally_clr);
      end else begin
        e = exp_q.pop_front();
        if (a === e) passes++;
        else $display("FAIL resp got ack=%b nack=%b tv=%b en=%b clr=%b st=%b tot=%0d done=%b required ack=%b nack=%b tv=%b en=%b clr=%b st=%b tot=%0d done=%b",
                      a.ack, a.nack, a.tv, a.en, a.clr, a.st, a.tot, a.done,
                      e.ack, e.nack, e.tv, e.en, e.clr, e.st, e.tot, e.done);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_resp(input logic [3:0] ack, input logic [3:0] nack,
                             input logic [3:0] tv, input logic clr,
                             input logic [1:0] st, input logic [4:0] tot);
    resp_t r;
    r = {ack, nack, tv, (tv != 4'b0000), clr, st, tot, (st == ST_CLOSED)};
    exp_q.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s got %0h required %0h", name, act, req);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_outs"}, 32'({booth_ack, booth_nack, tally_vote, tally_en, tally_clr, session_done}), 32'd0);
    check({tag, "_state"}, 32'(session_state), 32'(ST_IDLE));
    check({tag, "_total"}, 32'(total_votes), 32'd0);
  endtask

  task automatic vote(input int b, input logic [3:0] v);
    booth_req[b] = 1'b1;
    booth_vote[4*b +: 4] = v;
  endtask

  initial begin
    repeat (3) tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();

    // First session: clear pulse, then booth0 accepted
    open_i = 1'b1;
    expect_resp(4'b0000, 4'b0000, 4'b0000, 1'b1, ST_OPEN, 5'd0);
    tick(); open_i = 1'b0;
    vote(0, 4'b1000);
    expect_resp(4'b0001, 4'b0000, 4'b1000, 1'b0, ST_OPEN, 5'd1);
    tick(); booth_req[0] = 1'b0;
    vote(3, 4'b0010);
    expect_resp(4'b1000, 4'b0000, 4'b0010, 1'b0, ST_OPEN, 5'd2);
    tick(); booth_req[3] = 1'b0;

    // All four booths at once, pointer at 0
    vote(0, 4'b1000); vote(1, 4'b0100); vote(2, 4'b0010); vote(3, 4'b0001);
    expect_resp(4'b0001, 4'b0000, 4'b1000, 1'b0, ST_OPEN, 5'd3);
    tick(); booth_req[0] = 1'b0;
    expect_resp(4'b0010, 4'b0000, 4'b0100, 1'b0, ST_OPEN, 5'd4);
    tick(); booth_req[1] = 1'b0;
    expect_resp(4'b0100, 4'b0000, 4'b0010, 1'b0, ST_OPEN, 5'd5);
    tick(); booth_req[2] = 1'b0;
    expect_resp(4'b1000, 4'b0000, 4'b0001, 1'b0, ST_OPEN, 5'd6);
    tick(); booth_req[3] = 1'b0;

    // Multi-hot and empty votes rejected
    vote(2, 4'b1100);
    expect_resp(4'b0000, 4'b0100, 4'b0000, 1'b0, ST_OPEN, 5'd6);
    tick(); booth_req[2] = 1'b0;
    vote(3, 4'b0000);
    expect_resp(4'b0000, 4'b1000, 4'b0000, 1'b0, ST_OPEN, 5'd6);
    tick(); booth_req[3] = 1'b0;

    // Seventh vote auto-closes; the other pending booth is nacked in CLOSED
    vote(0, 4'b1000); vote(1, 4'b0100);
    expect_resp(4'b0001, 4'b0000, 4'b1000, 1'b0, ST_CLOSED, 5'd7);
    tick(); booth_req[0] = 1'b0;
    expect_resp(4'b0000, 4'b0010, 4'b0000, 1'b0, ST_CLOSED, 5'd7);
    tick(); booth_req[1] = 1'b0;

    // Reopen, then reset with booth1 pending
    open_i = 1'b1;
    expect_resp(4'b0000, 4'b0000, 4'b0000, 1'b1, ST_OPEN, 5'd0);
    tick(); open_i = 1'b0;
    vote(1, 4'b0100);
    #2 reset = 1'b1;
    tick();
    check_cleared("midreset");
    reset = 1'b0;
    expect_resp(4'b0000, 4'b0010, 4'b0000, 1'b0, ST_IDLE, 5'd0);
    tick(); booth_req[1] = 1'b0;

    // close_i together with a valid vote: vote counts, then closed
    open_i = 1'b1;
    expect_resp(4'b0000, 4'b0000, 4'b0000, 1'b1, ST_OPEN, 5'd0);
    tick(); open_i = 1'b0;
    close_i = 1'b1;
    vote(2, 4'b0001);
    expect_resp(4'b0100, 4'b0000, 4'b0001, 1'b0, ST_CLOSED, 5'd1);
    tick(); booth_req[2] = 1'b0;

    // open+close in CLOSED opens; open+close in OPEN closes
    open_i = 1'b1; close_i = 1'b1;
    expect_resp(4'b0000, 4'b0000, 4'b0000, 1'b1, ST_OPEN, 5'd0);
    tick();
    tick(); open_i = 1'b0; close_i = 1'b0;
    check("open_close_in_open", 32'(session_state), 32'(ST_CLOSED));
    vote(0, 4'b1000);
    expect_resp(4'b0000, 4'b0001, 4'b0000, 1'b0, ST_CLOSED, 5'd0);
    tick(); booth_req[0] = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    repeat (2) tick();
    check("pending_responses", 32'(exp_q.size()), 32'd0);
    check("final_done", 32'(session_done), 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
